// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU instruction sequencer and its ALU.
// State encoding, unary-flag position helper, ALU op codes.
package alu_seq_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_IN1  = 3'd1;
  localparam logic [ST_W-1:0] S_IN2  = 3'd2;
  localparam logic [ST_W-1:0] S_EVAL = 3'd3;
  localparam logic [ST_W-1:0] S_OUT  = 3'd4;
  localparam logic [ST_W-1:0] S_FIN  = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  // The unary flag sits just above the ALU operation field.
  function automatic int unary_bit(int opc_w);
    return opc_w;
  endfunction

endpackage

// File: rtl/alu_seq_idx_dec.sv
// Index decoder: idx + en -> N-bit one-hot, plus idx < N flag.
// Ports: idx, en in; onehot, in_range out.
module alu_seq_idx_dec #(
  parameter int N     = 6,
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot,
  output logic             in_range
);

  localparam logic [IDX_W:0] NL = (IDX_W+1)'(N);

  logic [IDX_W:0] idx_x;

  assign idx_x    = {1'b0, idx};
  assign in_range = idx_x < NL;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en & (idx_x == (IDX_W+1)'(i));
    end
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: IN1, IN2, EVAL, OUT, FIN per instruction.
// Ports: clk, reset, start, op, ri, rj in; strobes, busy, done, err out.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int NP_RW = 1,
  parameter int NP_RO = 1,
  parameter int IDX_W = 6,
  parameter int OPC_W = 3,
  localparam int NSRC = NREG + NP_RW + NP_RO,
  localparam int NDST = NREG + NP_RW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPC_W:0]   op,
  input  logic [IDX_W-1:0] ri,
  input  logic [IDX_W-1:0] rj,
  output logic [NSRC-1:0]  src_rd,
  output logic [NDST-1:0]  dst_wr,
  output logic             alu_wr_in1,
  output logic             alu_wr_in2,
  output logic             alu_out_en,
  output logic             alu_rd,
  output logic [OPC_W-1:0] alu_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int UB = unary_bit(OPC_W);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nx;
  logic [OPC_W:0]   op_q;
  logic [IDX_W-1:0] ri_q;
  logic [IDX_W-1:0] rj_q;
  logic             err_q;

  logic [IDX_W-1:0] src_idx;
  logic [IDX_W-1:0] dst_idx;
  logic             src_en;
  logic             dst_en;
  logic             src_ok;
  logic             dst_ok;
  logic             legal;
  logic             accept;

  // In IDLE the decoders see the live indices with strobes disabled,
  // so their range flags double as the legality check.
  always_comb begin
    src_idx = ri_q;
    case (state)
      S_IDLE:  src_idx = rj;
      S_IN2:   src_idx = rj_q;
      default: src_idx = ri_q;
    endcase
  end

  assign dst_idx = (state == S_IDLE) ? ri : ri_q;
  assign src_en  = (state == S_IN1) | (state == S_IN2);
  assign dst_en  = (state == S_OUT);

  alu_seq_idx_dec #(.N(NSRC), .IDX_W(IDX_W)) u_src_dec (
    .idx      (src_idx),
    .en       (src_en),
    .onehot   (src_rd),
    .in_range (src_ok)
  );

  alu_seq_idx_dec #(.N(NDST), .IDX_W(IDX_W)) u_dst_dec (
    .idx      (dst_idx),
    .en       (dst_en),
    .onehot   (dst_wr),
    .in_range (dst_ok)
  );

  assign legal  = dst_ok & (op[UB] | src_ok);
  assign accept = (state == S_IDLE) & start;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = legal ? S_IN1 : S_FIN;
      S_IN1:   state_nx = op_q[UB] ? S_EVAL : S_IN2;
      S_IN2:   state_nx = S_EVAL;
      S_EVAL:  state_nx = S_OUT;
      S_OUT:   state_nx = S_FIN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= '0;
      ri_q  <= '0;
      rj_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= op;
        ri_q  <= ri;
        rj_q  <= rj;
        err_q <= ~legal;
      end
    end
  end

  assign alu_wr_in1 = (state == S_IN1);
  assign alu_wr_in2 = (state == S_IN2);
  assign alu_out_en = (state == S_EVAL);
  assign alu_rd     = (state == S_OUT);
  assign alu_op     = alu_out_en ? op_q[OPC_W-1:0] : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign err        = done & err_q;

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Randomized bench for alu_seq_fsm, default and wide configurations.
// Expected per-cycle outputs come from a queue-based instruction model.
module tb_alu_seq_fsm;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic        in1;
    logic        in2;
    logic        oen;
    logic        ard;
    logic [2:0]  aop;
    logic        busy;
    logic        done;
    logic        err;
  } snap_t;

  typedef struct {
    logic [3:0] op;
    int         ri;
    int         rj;
  } dir_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [2];
  logic [3:0] op_s [2];
  logic [5:0] ri_s [2];
  logic [5:0] rj_s [2];

  logic [5:0]  src_a;
  logic [4:0]  dst_a;
  logic [11:0] src_b;
  logic [9:0]  dst_b;
  logic        in1_a, in2_a, oen_a, ard_a, busy_a, done_a, err_a;
  logic        in1_b, in2_b, oen_b, ard_b, busy_b, done_b, err_b;
  logic [2:0]  aop_a, aop_b;

  int n_tests = 0;
  int n_fail  = 0;

  int nsrc_c [2] = '{6, 12};
  int ndst_c [2] = '{5, 10};

  snap_t q0 [$];
  snap_t q1 [$];
  dir_t  dir0 [$];
  dir_t  dir1 [$];

  always #5 clk = ~clk;

  alu_seq_fsm u_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_s[0]),
    .op         (op_s[0]),
    .ri         (ri_s[0]),
    .rj         (rj_s[0]),
    .src_rd     (src_a),
    .dst_wr     (dst_a),
    .alu_wr_in1 (in1_a),
    .alu_wr_in2 (in2_a),
    .alu_out_en (oen_a),
    .alu_rd     (ard_a),
    .alu_op     (aop_a),
    .busy       (busy_a),
    .done       (done_a),
    .err        (err_a)
  );

  alu_seq_fsm #(.NREG(8), .NP_RW(2), .NP_RO(2)) u_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_s[1]),
    .op         (op_s[1]),
    .ri         (ri_s[1]),
    .rj         (rj_s[1]),
    .src_rd     (src_b),
    .dst_wr     (dst_b),
    .alu_wr_in1 (in1_b),
    .alu_wr_in2 (in2_b),
    .alu_out_en (oen_b),
    .alu_rd     (ard_b),
    .alu_op     (aop_b),
    .busy       (busy_b),
    .done       (done_b),
    .err        (err_b)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic snap_t get_obs(int d);
    snap_t s;
    s = '0;
    if (d == 0) begin
      s.src = 32'(src_a); s.dst = 32'(dst_a);
      s.in1 = in1_a; s.in2 = in2_a; s.oen = oen_a; s.ard = ard_a;
      s.aop = aop_a; s.busy = busy_a; s.done = done_a; s.err = err_a;
    end else begin
      s.src = 32'(src_b); s.dst = 32'(dst_b);
      s.in1 = in1_b; s.in2 = in2_b; s.oen = oen_b; s.ard = ard_b;
      s.aop = aop_b; s.busy = busy_b; s.done = done_b; s.err = err_b;
    end
    return s;
  endfunction

  task automatic cmp(int d, string ph, snap_t g, snap_t e);
    string p;
    p = $sformatf("d%0d.%s.", d, ph);
    check({p, "src_rd"}, g.src, e.src);
    check({p, "dst_wr"}, g.dst, e.dst);
    check({p, "in1"}, 32'(g.in1), 32'(e.in1));
    check({p, "in2"}, 32'(g.in2), 32'(e.in2));
    check({p, "out_en"}, 32'(g.oen), 32'(e.oen));
    check({p, "alu_rd"}, 32'(g.ard), 32'(e.ard));
    check({p, "alu_op"}, 32'(g.aop), 32'(e.aop));
    check({p, "busy"}, 32'(g.busy), 32'(e.busy));
    check({p, "done"}, 32'(g.done), 32'(e.done));
    check({p, "err"}, 32'(g.err), 32'(e.err));
  endtask

  // Expected cycles after acceptance, ending with the first IDLE cycle.
  function automatic void build(int d, logic [3:0] op, int ri, int rj);
    snap_t s;
    snap_t seq [$];
    bit un;
    bit legal;
    un = op[3];
    legal = (ri < ndst_c[d]) && (un || rj < nsrc_c[d]);
    if (!legal) begin
      s = '0; s.busy = 1; s.done = 1; s.err = 1;
      seq.push_back(s);
    end else begin
      s = '0; s.busy = 1; s.in1 = 1; s.src = 32'(1) << ri;
      seq.push_back(s);
      if (!un) begin
        s = '0; s.busy = 1; s.in2 = 1; s.src = 32'(1) << rj;
        seq.push_back(s);
      end
      s = '0; s.busy = 1; s.oen = 1; s.aop = op[2:0];
      seq.push_back(s);
      s = '0; s.busy = 1; s.ard = 1; s.dst = 32'(1) << ri;
      seq.push_back(s);
      s = '0; s.busy = 1; s.done = 1;
      seq.push_back(s);
    end
    s = '0;
    seq.push_back(s);
    foreach (seq[k]) begin
      if (d == 0) q0.push_back(seq[k]);
      else        q1.push_back(seq[k]);
    end
  endfunction

  function automatic int rnd_idx(int d);
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 63));
    return int'($urandom_range(0, nsrc_c[d] + 1));
  endfunction

  task automatic drive(int d);
    bit idle;
    bit have_dir;
    dir_t t;
    idle = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    have_dir = (d == 0) ? (dir0.size() != 0) : (dir1.size() != 0);
    t.op = 4'($urandom_range(0, 15));
    t.ri = rnd_idx(d);
    t.rj = rnd_idx(d);
    start_s[d] = ($urandom_range(0, 3) != 0);
    if (idle && have_dir) begin
      t = (d == 0) ? dir0.pop_front() : dir1.pop_front();
      start_s[d] = 1'b1;
    end
    op_s[d] = t.op;
    ri_s[d] = 6'(t.ri);
    rj_s[d] = 6'(t.rj);
    if (idle && start_s[d]) build(d, t.op, t.ri, t.rj);
  endtask

  task automatic run_cycle(input bit rst_on_eval, output bit hit);
    snap_t e;
    @(negedge clk);
    hit = 0;
    for (int d = 0; d < 2; d++) begin
      e = '0;
      if (d == 0 && q0.size() != 0) e = q0.pop_front();
      if (d == 1 && q1.size() != 0) e = q1.pop_front();
      cmp(d, "cyc", get_obs(d), e);
      if (rst_on_eval && d == 0 && e.oen) hit = 1;
    end
    if (hit) begin
      reset = 1'b1;
      #1;
      e = '0;
      cmp(0, "rst", get_obs(0), e);
      cmp(1, "rst", get_obs(1), e);
      q0.delete();
      q1.delete();
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      dir0.push_back('{4'b0_110, 2, 3});
      return;
    end
    reset = 1'b0;
    drive(0);
    drive(1);
  endtask

  initial begin
    bit hit;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      op_s[d] = '0;
      ri_s[d] = '0;
      rj_s[d] = '0;
    end
    dir0.push_back('{4'b0_010, 1, 5});
    dir0.push_back('{4'b1_101, 4, 0});
    dir0.push_back('{4'b0_001, 5, 0});
    dir0.push_back('{4'b0_011, 0, 6});
    dir0.push_back('{4'b1_100, 4, 63});
    dir1.push_back('{4'b0_011, 9, 11});
    dir1.push_back('{4'b0_001, 10, 0});
    dir1.push_back('{4'b0_000, 0, 12});
    dir1.push_back('{4'b1_111, 9, 63});
    #1;
    begin
      snap_t z;
      z = '0;
      cmp(0, "por", get_obs(0), z);
      cmp(1, "por", get_obs(1), z);
    end
    for (int i = 0; i < 300; i++) run_cycle(1'b0, hit);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) run_cycle(1'b1, hit);
    if (!hit) check("rst_eval_reached", 32'(hit), 32'(1));
    for (int i = 0; i < 300; i++) run_cycle(1'b0, hit);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_fsm.md
# alu_seq_fsm

Parametrised ALU instruction sequencer for the register-ALU datapath. It accepts one `0111 Ri Rj`-class ALU instruction per `start` and sequences the datapath through four phases: operand 1 load, operand 2 load, evaluate, and write-back. It drives one-hot read and write strobes for a configurable register file and port set. Compared with the fixed 4-register controller, it adds instruction latching, a unary mode that skips operand 2, illegal-index detection with an error completion, and a `busy` output.

## Interface
- `NREG`, 4, number of general registers; index space 0..NREG-1
- `NP_RW`, 1, read/write ports; indices NREG..NREG+NP_RW-1
- `NP_RO`, 1, read-only ports; indices follow the read/write ports
- `IDX_W`, 6, width of `ri`/`rj`
- `OPC_W`, 3, ALU op-control width
- Derived values: NSRC = NREG+NP_RW+NP_RO; NDST = NREG+NP_RW
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  instruction valid; sampled only in IDLE
- `op`  in  OPC_W+1  bit OPC_W = unary flag; bits OPC_W-1:0 = ALU operation
- `ri`  in  IDX_W  operand 1 source and destination index
- `rj`  in  IDX_W  operand 2 source index; ignored when unary
- `src_rd`  out  NSRC  one-hot source read enable
- `dst_wr`  out  NDST  one-hot destination write enable
- `alu_wr_in1`, `alu_wr_in2`, `alu_out_en`, `alu_rd`  out  1 each  ALU strobes
- `alu_op`  out  OPC_W  ALU operation; nonzero only in EVAL
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; marks an illegal index

## Operation
- States: IDLE, IN1, IN2, EVAL, OUT, FIN.
- IDLE + `start`:
  - Latch `op`, `ri`, `rj`.
  - Legal iff ri < NDST and (unary or rj < NSRC).
  - Legal goes to IN1. Illegal latches err=1 and goes straight to FIN.
- Transitions:
  - IN1 -> IN2, or IN1 -> EVAL when unary.
  - IN2 -> EVAL -> OUT -> FIN -> IDLE.
- Outputs are Moore, decoded from the state and latched fields only. Live `op`/`ri`/`rj` never affect outputs after acceptance.
- Output per state (every strobe not listed is 0):
  - IN1: `src_rd[ri]`=1, `alu_wr_in1`=1.
  - IN2: `src_rd[rj]`=1, `alu_wr_in2`=1.
  - EVAL: `alu_out_en`=1, `alu_op`=latched op[OPC_W-1:0].
  - OUT: `alu_rd`=1, `dst_wr[ri]`=1.
  - FIN: `done`=1; `err`=latched err.
- At most one bit of `src_rd` is set at any time, and likewise for `dst_wr`. They are never both set in the same cycle.
- `start` is ignored when not in IDLE, including during FIN.
- Reset, including mid-instruction: state returns to IDLE, the latched err clears, and all outputs go to 0 immediately (asynchronous).

## Timing
- Reset values: every output is 0, with `busy`=0.
- `start` sampled at edge 0 for a binary op: IN1 in cycle 1, IN2 in 2, EVAL in 3, OUT in 4, FIN in 5 (`done`), IDLE in 6.
- Unary op: IN1 in 1, EVAL in 2, OUT in 3, FIN in 4.
- Illegal index: FIN in cycle 1 with `done`=`err`=1. No strobe asserts at any point.
- Back-to-back: the earliest next accepted `start` is at the first IDLE cycle. Throughput is 1 instruction per 6 cycles for binary ops and per 5 for unary ops.
- `done` is exactly one cycle wide.

## Structure
- Package `alu_seq_pkg`: state encoding constants, the unary-flag bit position, and ALU op-code constants shared with the ALU.
- One sub-module, `alu_seq_idx_dec`. It is parametrised by width N and converts an index plus an enable into an N-bit one-hot plus an in-range flag. It is instantiated twice: once for the source decode and once for the destination decode.

## Test plan
- Default parameters, op=0_010, ri=1, rj=5 -> `src_rd`=000010 in cycle 1, 100000 in cycle 2, `alu_op`=010 in cycle 3, `dst_wr`=00010 with `alu_rd` in cycle 4, `done` in cycle 5 with `err`=0.
- Unary op=1_101, ri=4 -> IN2 skipped, `dst_wr`=10000 in cycle 3, `done` in cycle 4.
- ri=5 (read-only port as destination), and separately rj=6 -> `done`=`err`=1 in cycle 1, no strobes.
- `start` held high continuously, with `ri`/`rj` changed during the instruction -> instructions accepted only in IDLE, and strobes follow the latched indices.
- `reset` asserted during EVAL -> all outputs 0 immediately. The next `start` runs a clean 6-cycle sequence.
- NREG=8, NP_RW=2, NP_RO=2, ri=9, rj=11 -> `src_rd` bit 9 then bit 11, `dst_wr` bit 9, `err`=0.
